// File: rtl/fetch_issue.sv
// Instruction-fetch front end: PC register, 1-cycle synchronous imem interface,
// 1-entry skid buffer for decode stalls, redirect flush. Optional perf counters under FETCH_PERF_EN.
module fetch_issue #(
    parameter logic [31:0] RESET_PC  = 32'h0000_2000,
    parameter logic [31:0] NOP_INSTR = 32'h0000_0013
) (
    input  logic        clk,
    input  logic        rst_n,
    output logic        imem_en,
    output logic [31:0] imem_addr,
    input  logic [31:0] imem_rdata,
    input  logic        stall,
    input  logic        redirect_valid,
    input  logic [31:0] redirect_pc,
    output logic        out_valid,
    output logic [31:0] out_instr,
    output logic [31:0] out_pc,
    output logic        out_bubble
`ifdef FETCH_PERF_EN
    ,
    output logic [31:0] perf_fetched,
    output logic [31:0] perf_flushed
`endif
);

    logic [31:0] pc_q, pc_d;
    logic        infl_q, infl_d;
    logic [31:0] infl_pc_q, infl_pc_d;
    logic        skid_vld_q, skid_vld_d;
    logic [31:0] skid_instr_q, skid_instr_d;
    logic [31:0] skid_pc_q, skid_pc_d;
    logic        out_vld_q, out_vld_d;
    logic [31:0] out_instr_q, out_instr_d;
    logic [31:0] out_pc_q, out_pc_d;

    logic        issue;
    logic [31:0] iss_addr;

    // A redirect always issues; otherwise issue only when the skid is free and decode is moving,
    // which is what keeps at most one request outstanding and the skid from overflowing.
    assign issue    = redirect_valid | (~stall & ~skid_vld_q);
    assign iss_addr = redirect_valid ? {redirect_pc[31:2], 2'b00} : pc_q;

    assign imem_en    = issue & rst_n;
    assign imem_addr  = iss_addr;
    assign out_valid  = out_vld_q;
    assign out_instr  = out_instr_q;
    assign out_pc     = out_pc_q;
    assign out_bubble = ~out_vld_q;

    always_comb begin
        pc_d         = pc_q;
        infl_d       = 1'b0;
        infl_pc_d    = infl_pc_q;
        skid_vld_d   = skid_vld_q;
        skid_instr_d = skid_instr_q;
        skid_pc_d    = skid_pc_q;
        out_vld_d    = out_vld_q;
        out_instr_d  = out_instr_q;
        out_pc_d     = out_pc_q;

        if (issue) begin
            pc_d      = {iss_addr[31:2] + 30'd1, 2'b00};
            infl_d    = 1'b1;
            infl_pc_d = iss_addr;
        end

        if (redirect_valid) begin
            // Flush: the arriving response and any skid entry are wrong-path.
            skid_vld_d  = 1'b0;
            out_vld_d   = 1'b0;
            out_instr_d = NOP_INSTR;
            out_pc_d    = 32'h0;
        end else if (!stall) begin
            if (skid_vld_q) begin
                out_vld_d    = 1'b1;
                out_instr_d  = skid_instr_q;
                out_pc_d     = skid_pc_q;
                skid_vld_d   = infl_q;
                skid_instr_d = infl_q ? imem_rdata : skid_instr_q;
                skid_pc_d    = infl_q ? infl_pc_q : skid_pc_q;
            end else if (infl_q) begin
                out_vld_d   = 1'b1;
                out_instr_d = imem_rdata;
                out_pc_d    = infl_pc_q;
            end else begin
                out_vld_d   = 1'b0;
                out_instr_d = NOP_INSTR;
                out_pc_d    = 32'h0;
            end
        end else if (infl_q) begin
            skid_vld_d   = 1'b1;
            skid_instr_d = imem_rdata;
            skid_pc_d    = infl_pc_q;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pc_q         <= RESET_PC;
            infl_q       <= 1'b0;
            infl_pc_q    <= 32'h0;
            skid_vld_q   <= 1'b0;
            skid_instr_q <= NOP_INSTR;
            skid_pc_q    <= 32'h0;
            out_vld_q    <= 1'b0;
            out_instr_q  <= NOP_INSTR;
            out_pc_q     <= 32'h0;
        end else begin
            pc_q         <= pc_d;
            infl_q       <= infl_d;
            infl_pc_q    <= infl_pc_d;
            skid_vld_q   <= skid_vld_d;
            skid_instr_q <= skid_instr_d;
            skid_pc_q    <= skid_pc_d;
            out_vld_q    <= out_vld_d;
            out_instr_q  <= out_instr_d;
            out_pc_q     <= out_pc_d;
        end
    end

`ifdef FETCH_PERF_EN
    logic [31:0] fetched_q, fetched_d;
    logic [31:0] flushed_q, flushed_d;
    logic [1:0]  n_flush;

    // An out entry is only lost to a redirect if decode is not taking it that same cycle.
    always_comb begin
        n_flush   = 2'(infl_q) + 2'(skid_vld_q) + 2'(out_vld_q & stall);
        fetched_d = fetched_q + 32'(out_vld_q & ~stall);
        flushed_d = redirect_valid ? flushed_q + 32'(n_flush) : flushed_q;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            fetched_q <= 32'h0;
            flushed_q <= 32'h0;
        end else begin
            fetched_q <= fetched_d;
            flushed_q <= flushed_d;
        end
    end

    assign perf_fetched = fetched_q;
    assign perf_flushed = flushed_q;
`endif

endmodule

// File: tb/tb_fetch_issue.sv
// Directed bench for fetch_issue: queue-based stream model checked every cycle, plus literal pins.
module tb_fetch_issue;

    localparam logic [31:0] RPC = 32'h0000_2000;
    localparam logic [31:0] NOP = 32'h0000_0013;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        imem_en;
    logic [31:0] imem_addr;
    logic [31:0] imem_rdata = 32'h0;
    logic        stall = 1'b0;
    logic        redirect_valid = 1'b0;
    logic [31:0] redirect_pc = 32'h0;
    logic        out_valid;
    logic [31:0] out_instr;
    logic [31:0] out_pc;
    logic        out_bubble;
`ifdef FETCH_PERF_EN
    logic [31:0] perf_fetched;
    logic [31:0] perf_flushed;
`endif

    int checks = 0;
    int failures = 0;
    bit chk_on = 1'b0;

    fetch_issue #(.RESET_PC(RPC), .NOP_INSTR(NOP)) dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .imem_en       (imem_en),
        .imem_addr     (imem_addr),
        .imem_rdata    (imem_rdata),
        .stall         (stall),
        .redirect_valid(redirect_valid),
        .redirect_pc   (redirect_pc),
        .out_valid     (out_valid),
        .out_instr     (out_instr),
        .out_pc        (out_pc),
        .out_bubble    (out_bubble)
`ifdef FETCH_PERF_EN
        ,
        .perf_fetched  (perf_fetched),
        .perf_flushed  (perf_flushed)
`endif
    );

    always #5 clk = ~clk;

    function automatic logic [31:0] memf(input logic [31:0] a);
        return a ^ 32'hC0DE_0000;
    endfunction

    always @(posedge clk) if (imem_en) imem_rdata <= memf(imem_addr);

    // Model: the PC that will be fetched next, what is in flight, and an ordered queue of
    // returned-but-undelivered instructions. Decode sees the queue head whenever it is not stalled.
    logic [31:0] m_pc;
    bit          m_infl;
    logic [31:0] m_infl_pc;
    logic [31:0] m_q[$];
    bit          m_ov;
    logic [31:0] m_opc;

    task automatic model_reset();
        m_pc = RPC; m_infl = 0; m_infl_pc = 0; m_q.delete(); m_ov = 0; m_opc = 0;
    endtask

    task automatic model_step();
        bit iss;
        logic [31:0] a;
        iss = redirect_valid || (!stall && m_q.size() == 0);
        a   = redirect_valid ? {redirect_pc[31:2], 2'b00} : m_pc;
        if (redirect_valid) begin
            m_q.delete();
            m_ov = 0;
        end else begin
            if (m_infl) m_q.push_back(m_infl_pc);
            if (!stall) begin
                if (m_q.size() > 0) begin m_ov = 1; m_opc = m_q.pop_front(); end
                else m_ov = 0;
            end
        end
        m_infl = iss;
        if (iss) begin m_infl_pc = a; m_pc = a + 32'd4; end
    endtask

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s t=%0t act=%h exp=%h", nm, $time, act, exp);
        end
    endtask

    always @(negedge clk) begin
        if (chk_on) begin
            bit e_iss;
            e_iss = rst_n && (redirect_valid || (!stall && m_q.size() == 0));
            chk("imem_en", {31'b0, imem_en}, {31'b0, e_iss});
            if (e_iss)
                chk("imem_addr", imem_addr, redirect_valid ? {redirect_pc[31:2], 2'b00} : m_pc);
            chk("out_valid", {31'b0, out_valid}, {31'b0, m_ov});
            chk("out_bubble", {31'b0, out_bubble}, {31'b0, !m_ov});
            chk("out_pc", out_pc, m_ov ? m_opc : 32'h0);
            chk("out_instr", out_instr, m_ov ? memf(m_opc) : NOP);
        end
    end

    task automatic drive(input bit st, input bit rv, input logic [31:0] rp);
        stall = st; redirect_valid = rv; redirect_pc = rp;
    endtask

    task automatic tick();
        @(posedge clk);
        if (rst_n) model_step();
        #1;
    endtask

    task automatic run(input int n);
        drive(0, 0, 0);
        for (int i = 0; i < n; i++) tick();
    endtask

    initial begin
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        chk("rst_out_valid", {31'b0, out_valid}, 32'd0);
        chk("rst_out_instr", out_instr, 32'h0000_0013);
        chk("rst_out_pc", out_pc, 32'h0);
        chk("rst_out_bubble", {31'b0, out_bubble}, 32'd1);
        chk("rst_imem_en", {31'b0, imem_en}, 32'd0);
        chk_on = 1'b1;

        // Release: first issue is RESET_PC, first valid two cycles later.
        rst_n = 1'b1;
        #1;
        chk("first_addr", imem_addr, 32'h0000_2000);
        chk("first_en", {31'b0, imem_en}, 32'd1);
        tick();
        chk("second_addr", imem_addr, 32'h0000_2004);
        tick();
        chk("first_out_pc", out_pc, 32'h0000_2000);
        chk("first_out_instr", out_instr, 32'hC0DE_2000);
        run(4);
        chk("stream_out_pc", out_pc, 32'h0000_2010);

        // Three-cycle stall mid-stream.
        drive(1, 0, 0);
        for (int i = 0; i < 3; i++) tick();
        chk("stall_hold_pc", out_pc, 32'h0000_2010);
        chk("stall_no_issue", {31'b0, imem_en}, 32'd0);
        drive(0, 0, 0);
        tick();
        chk("skid_first", out_pc, 32'h0000_2014);
        chk("resume_addr", imem_addr, 32'h0000_2018);
        run(5);

        // Redirect to an unaligned target.
        drive(0, 1, 32'h0000_3001);
        #1;
        chk("redir_addr", imem_addr, 32'h0000_3000);
        tick();
        drive(0, 0, 0);
        chk("redir_bubble", {31'b0, out_bubble}, 32'd1);
        chk("redir_nop", out_instr, 32'h0000_0013);
        tick();
        chk("redir_tgt", out_pc, 32'h0000_3000);
        tick();
        chk("redir_tgt4", out_pc, 32'h0000_3004);
        run(3);

        // Back-to-back redirects: only the last target is delivered.
        drive(0, 1, 32'h0000_5000); tick();
        drive(0, 1, 32'h0000_6000); tick();
        drive(0, 0, 0); tick();
        chk("b2b_tgt", out_pc, 32'h0000_6000);
        run(3);

        // Redirect under stall with a full skid.
        drive(1, 0, 0); tick();
        drive(1, 1, 32'h0000_4000);
        #1;
        chk("stall_redir_addr", imem_addr, 32'h0000_4000);
        tick();
        chk("stall_redir_bubble", {31'b0, out_valid}, 32'd0);
        drive(1, 0, 0); tick(); tick();
        drive(0, 0, 0); tick();
        chk("stall_redir_tgt", out_pc, 32'h0000_4000);
        run(4);

        // Async reset with a request in flight.
        rst_n = 1'b0;
        model_reset();
        #1;
        chk("rst2_out_valid", {31'b0, out_valid}, 32'd0);
        chk("rst2_out_instr", out_instr, 32'h0000_0013);
        chk("rst2_imem_en", {31'b0, imem_en}, 32'd0);
        tick();
        rst_n = 1'b1;
        #1;
        chk("rst2_restart", imem_addr, 32'h0000_2000);
        tick(); tick();
        chk("rst2_first_pc", out_pc, 32'h0000_2000);
        run(4);

        chk_on = 1'b0;
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
